// File: rtl/debug_streamer.sv
// rtl/debug_streamer.sv - probe capture to framed ASCII-hex byte stream ("ST" ... "SP").
// Optional per-sample CR/LF separator: define DEBUG_STREAMER_CRLF_EN.
module debug_streamer #(
    parameter int DATA_W  = 8,
    parameter int FIFO_AW = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] probe,
    input  logic              probe_valid,
    input  logic              trig_mode,
    input  logic              btn_start,
    input  logic              btn_stop,
    input  logic              tx_full,
    output logic              tx_wr,
    output logic [7:0]        tx_data,
    output logic              running,
    output logic              overflow,
    output logic [FIFO_AW:0]  fifo_level
);
    localparam int NIBBLES = DATA_W / 4;
`ifdef DEBUG_STREAMER_CRLF_EN
    localparam int SEP_LEN = 2;
`else
    localparam int SEP_LEN = 0;
`endif
    localparam int SAMPLE_LEN = NIBBLES + SEP_LEN;
    localparam int CNT_W      = $clog2(SAMPLE_LEN + 1);
    localparam int DEPTH      = 1 << FIFO_AW;

    localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(SAMPLE_LEN - 1);
    localparam logic [CNT_W-1:0]   SEP_CNT  = CNT_W'(SEP_LEN);
    localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
    localparam logic [FIFO_AW-1:0] PTR_ONE  = FIFO_AW'(1);
    localparam logic [FIFO_AW:0]   LVL_ONE  = (FIFO_AW + 1)'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_RUN,
        S_DRAIN,
        S_TRL
    } state_t;

    state_t             state;
    logic               pending;
    logic               second_byte;
    logic [DATA_W-1:0]  prev;
    logic [DATA_W-1:0]  shreg;
    logic [CNT_W-1:0]   rem;
    logic [FIFO_AW-1:0] wptr;
    logic [FIFO_AW-1:0] rptr;
    logic [DATA_W-1:0]  mem [DEPTH];

    logic accept;
    logic fifo_empty;
    logic fifo_full;
    logic ser_active;
    logic ser_idle;
    logic trigger;
    logic push;
    logic pop;

    function automatic logic [7:0] hex_char(input logic [3:0] nib);
        return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
    endfunction

    assign accept     = pending && !tx_full;
    assign tx_wr      = accept;
    assign fifo_empty = (fifo_level == '0);
    assign fifo_full  = fifo_level[FIFO_AW];
    assign ser_active = (state == S_RUN) || (state == S_DRAIN);
    // Idle also covers the cycle the last byte of a sample is taken, so samples chain without a gap.
    assign ser_idle   = !pending || (accept && (rem == '0));
    assign trigger    = (state == S_RUN) && !btn_stop && probe_valid
                        && (trig_mode || (probe != prev));
    assign push       = trigger && !fifo_full;
    assign pop        = ser_active && ser_idle && !fifo_empty;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= probe;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            pending     <= 1'b0;
            second_byte <= 1'b0;
            tx_data     <= 8'h00;
            running     <= 1'b0;
            overflow    <= 1'b0;
            prev        <= '0;
            shreg       <= '0;
            rem         <= '0;
            wptr        <= '0;
            rptr        <= '0;
            fifo_level  <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + PTR_ONE;
            end
            if (pop) begin
                rptr <= rptr + PTR_ONE;
            end
            if (push && !pop) begin
                fifo_level <= fifo_level + LVL_ONE;
            end else if (pop && !push) begin
                fifo_level <= fifo_level - LVL_ONE;
            end
            // A trigger on a full FIFO still updates prev; only the storage is lost.
            if (trigger) begin
                prev <= probe;
                if (fifo_full) begin
                    overflow <= 1'b1;
                end
            end

            case (state)
                S_IDLE: begin
                    if (btn_start) begin
                        state       <= S_HDR;
                        overflow    <= 1'b0;
                        tx_data     <= 8'h53;
                        pending     <= 1'b1;
                        second_byte <= 1'b0;
                    end
                end
                S_HDR: begin
                    if (accept) begin
                        if (!second_byte) begin
                            tx_data     <= 8'h54;
                            second_byte <= 1'b1;
                        end else begin
                            state   <= S_RUN;
                            running <= 1'b1;
                            pending <= 1'b0;
                            prev    <= probe;
                        end
                    end
                end
                S_RUN, S_DRAIN: begin
                    if ((state == S_RUN) && btn_stop) begin
                        state   <= S_DRAIN;
                        running <= 1'b0;
                    end
                    if (pop) begin
                        tx_data <= hex_char(mem[rptr][DATA_W-1 -: 4]);
                        shreg   <= mem[rptr] << 4;
                        rem     <= LAST_CNT;
                        pending <= 1'b1;
                    end else if (accept) begin
                        if (rem == '0) begin
                            pending <= 1'b0;
                        end else begin
                            rem <= rem - CNT_ONE;
                            if (rem > SEP_CNT) begin
                                tx_data <= hex_char(shreg[DATA_W-1 -: 4]);
                                shreg   <= shreg << 4;
`ifdef DEBUG_STREAMER_CRLF_EN
                            end else if (rem == CNT_W'(2)) begin
                                tx_data <= 8'h0D;
                            end else begin
                                tx_data <= 8'h0A;
`endif
                            end
                        end
                    end
                    if ((state == S_DRAIN) && fifo_empty && ser_idle) begin
                        state       <= S_TRL;
                        tx_data     <= 8'h53;
                        pending     <= 1'b1;
                        second_byte <= 1'b0;
                    end
                end
                S_TRL: begin
                    if (accept) begin
                        if (!second_byte) begin
                            tx_data     <= 8'h50;
                            second_byte <= 1'b1;
                        end else begin
                            state   <= S_IDLE;
                            pending <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule
